md_seq: RTL

MD_SEQ -- requirements
Module: md_seq

---
 rtl/md_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/md_seq.sv
// Sequencer for RISC-V M-extension ops: drives a shared external multiplier, runs an
// internal restoring divider, and serves results from a one-entry operand/result cache.
module md_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_kill,
  output logic        resp_done,
  output logic [31:0] resp_result,
  output logic        busy,
  output logic        mul_go,
  output logic        mul_sign0,
  output logic        mul_sign1,
  output logic [31:0] mul_m,
  output logic [31:0] mul_r,
  input  logic        mul_done,
  input  logic [63:0] mul_result
);

  typedef enum logic [1:0] {StIdle, StMulWait, StDivRun, StDivFix} state_e;
  typedef enum logic [2:0] {ClsMulSS, ClsMulSU, ClsMulUU, ClsDivS, ClsDivU} cls_e;

  state_e      state_q;
  cls_e        req_cls;

  // Cache: w0 holds hi/quotient, w1 holds lo/remainder.
  logic        c_valid_q;
  logic [31:0] c_a_q, c_b_q, c_w0_q, c_w1_q;
  cls_e        c_cls_q;

  logic [31:0] quo_q, rem_q, dvs_q;
  logic [4:0]  cnt_q;
  logic        q_neg_q, r_neg_q;

  logic        hit, is_mul, div_signed, a_neg, b_neg, div_ovf, abort;
  logic [31:0] a_mag, b_mag, q_fix, r_fix;
  logic [32:0] rem_shift, rem_diff;
  logic        cache_we;
  logic [31:0] cache_w0, cache_w1;

  always_comb begin
    req_cls = ClsMulSS;
    case (req_funct3)
      3'b000, 3'b001: req_cls = ClsMulSS;
      3'b010:         req_cls = ClsMulSU;
      3'b011:         req_cls = ClsMulUU;
      3'b100, 3'b110: req_cls = ClsDivS;
      default:        req_cls = ClsDivU;
    endcase
  end

  assign is_mul     = ~req_funct3[2];
  assign div_signed = (req_cls == ClsDivS);
  assign hit        = c_valid_q && (c_cls_q == req_cls) && (c_a_q == req_a) && (c_b_q == req_b);
  assign a_neg      = div_signed & req_a[31];
  assign b_neg      = div_signed & req_b[31];
  assign a_mag      = a_neg ? (32'd0 - req_a) : req_a;
  assign b_mag      = b_neg ? (32'd0 - req_b) : req_b;
  assign div_ovf    = div_signed && (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
  assign abort      = !req_valid || req_kill;

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign rem_shift = {rem_q, quo_q[31]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};
  assign q_fix     = q_neg_q ? (32'd0 - quo_q) : quo_q;
  assign r_fix     = r_neg_q ? (32'd0 - rem_q) : rem_q;

  assign busy      = (state_q != StIdle);
  assign mul_go    = (state_q == StMulWait);
  assign mul_sign0 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001);
  assign mul_sign1 = mul_sign0 || (req_funct3 == 3'b010);
  assign mul_m     = req_a;
  assign mul_r     = req_b;
  assign resp_done = (state_q == StIdle) && req_valid && !req_kill && hit;

  always_comb begin
    resp_result = c_w1_q;
    case (req_funct3)
      3'b001, 3'b010, 3'b011, 3'b100, 3'b101: resp_result = c_w0_q;
      default:                                resp_result = c_w1_q;
    endcase
  end

  always_comb begin
    cache_we = 1'b0;
    cache_w0 = 32'd0;
    cache_w1 = 32'd0;
    case (state_q)
      StIdle: begin
        if (req_valid && !req_kill && !hit && !is_mul) begin
          if (req_b == 32'd0) begin
            cache_we = 1'b1;
            cache_w0 = 32'hFFFF_FFFF;
            cache_w1 = req_a;
          end else if (div_ovf) begin
            cache_we = 1'b1;
            cache_w0 = 32'h8000_0000;
            cache_w1 = 32'd0;
          end
        end
      end
      StMulWait: begin
        if (!abort && mul_done) begin
          cache_we = 1'b1;
          cache_w0 = mul_result[63:32];
          cache_w1 = mul_result[31:0];
        end
      end
      StDivFix: begin
        if (!abort) begin
          cache_we = 1'b1;
          cache_w0 = q_fix;
          cache_w1 = r_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_valid_q <= 1'b0;
      c_a_q     <= 32'd0;
      c_b_q     <= 32'd0;
      c_cls_q   <= ClsMulSS;
      c_w0_q    <= 32'd0;
      c_w1_q    <= 32'd0;
    end else if (cache_we) begin
      c_valid_q <= 1'b1;
      c_a_q     <= req_a;
      c_b_q     <= req_b;
      c_cls_q   <= req_cls;
      c_w0_q    <= cache_w0;
      c_w1_q    <= cache_w1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dvs_q   <= 32'd0;
      cnt_q   <= 5'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid && !req_kill && !hit) begin
            if (is_mul) begin
              state_q <= StMulWait;
            end else if ((req_b != 32'd0) && !div_ovf) begin
              quo_q   <= a_mag;
              dvs_q   <= b_mag;
              rem_q   <= 32'd0;
              cnt_q   <= 5'd31;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
              state_q <= StDivRun;
            end
          end
        end
        StMulWait: begin
          if (abort || mul_done) state_q <= StIdle;
        end
        StDivRun: begin
          if (abort) begin
            state_q <= StIdle;
          end else begin
            quo_q <= {quo_q[30:0], ~rem_diff[32]};
            rem_q <= rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];
            if (cnt_q == 5'd0) state_q <= StDivFix;
            else               cnt_q   <= cnt_q - 5'd1;
          end
        end
        StDivFix: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule
